// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - display bus and decoded frame bundle for seg7_capture
//
// Purpose: groups the multiplexed 7-segment display lines observed by the
// capture block together with the decoded frame it produces.
// Signals:
//   leds        [0:6]  segment lines a..g (leds[0]=a), active-low
//   digit_sel   [3:0]  digit selects, active-low one-hot, bit n = slot n
//   bcd         [15:0] last complete frame, slot n in bcd[4n+3:4n]
//   dash        [3:0]  slot n held the dash pattern
//   err         [3:0]  slot n held an unrecognised pattern
//   frame_valid        one-cycle pulse when bcd/dash/err update
// Modports:
//   master  drives the display lines, observes the frame
//   slave   observes the display lines, drives the frame
interface seg7_capture_if;
   logic [0:6]  leds;
   logic [3:0]  digit_sel;
   logic [15:0] bcd;
   logic [3:0]  dash;
   logic [3:0]  err;
   logic        frame_valid;

   modport master (
      output leds, digit_sel,
      input  bcd, dash, err, frame_valid
   );

   modport slave (
      input  leds, digit_sel,
      output bcd, dash, err, frame_valid
   );
endinterface

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - reverse decoder for a multiplexed active-low 4-digit 7-segment bus
//
// Purpose: waits for each digit's segment pattern to hold stable, decodes it
// back to BCD (plus dash / error flags) and publishes complete 4-digit frames.
// Parameters:
//   STABLE_CYCLES  consecutive identical registered samples before capture (1..255)
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high
//   disp   seg7_capture_if.slave: leds/digit_sel in, bcd/dash/err/frame_valid out
module seg7_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   seg7_capture_if.slave disp
);
   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [0:6]    leds_q;
   logic [3:0]    sel_q;
   logic [CW-1:0] cnt;
   logic          captured;
   logic [3:0]    seen;
   logic [15:0]   sh_bcd;
   logic [3:0]    sh_dash;
   logic [3:0]    sh_err;
   logic [15:0]   bcd_r;
   logic [3:0]    dash_r;
   logic [3:0]    err_r;
   logic          fv_r;

   logic          changed;
   logic          onehot;
   logic          capture;
   logic [1:0]    slot;
   logic [3:0]    nib;
   logic          is_dash;
   logic          is_err;
   logic [15:0]   nx_bcd;
   logic [3:0]    nx_dash;
   logic [3:0]    nx_err;
   logic [3:0]    nx_seen;

   always_comb begin
      // Comparing the pins against in_q means a change is seen on the edge
      // that loads it, so the new value starts its stable period at count 0.
      changed = ({disp.leds, disp.digit_sel} != {leds_q, sel_q});
      onehot  = ($countones(~sel_q) == 1);
      // A change on the capture edge itself vetoes the capture: the value
      // must survive STABLE_CYCLES+1 edges at the pins.
      capture = !changed && (cnt == CNT_MAX) && !captured && onehot;

      slot = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!sel_q[i]) slot = 2'(i);
      end

      is_dash = 1'b0;
      is_err  = 1'b0;
      case (leds_q)
         7'b0000001: nib = 4'h0;
         7'b1001111: nib = 4'h1;
         7'b0010010: nib = 4'h2;
         7'b0000110: nib = 4'h3;
         7'b1001100: nib = 4'h4;
         7'b0100100: nib = 4'h5;
         7'b1100000: nib = 4'h6;
         7'b0001111: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0001100: nib = 4'h9;
         7'b1111110: begin nib = 4'hF; is_dash = 1'b1; end
         default:    begin nib = 4'hE; is_err  = 1'b1; end
      endcase

      // Shadow contents as they will be after this capture; used both to
      // update the shadow and to publish a completing frame in one edge.
      nx_bcd                     = sh_bcd;
      nx_bcd[{slot, 2'b00} +: 4] = nib;
      nx_dash                    = sh_dash;
      nx_dash[slot]              = is_dash;
      nx_err                     = sh_err;
      nx_err[slot]               = is_err;
      nx_seen                    = seen;
      nx_seen[slot]              = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         leds_q   <= 7'b1111111;
         sel_q    <= 4'b1111;
         cnt      <= '0;
         // Set so that nothing is captured until a fresh change is seen.
         captured <= 1'b1;
         seen     <= 4'b0000;
         sh_bcd   <= 16'h0000;
         sh_dash  <= 4'b0000;
         sh_err   <= 4'b0000;
         bcd_r    <= 16'h0000;
         dash_r   <= 4'b0000;
         err_r    <= 4'b0000;
         fv_r     <= 1'b0;
      end else begin
         leds_q <= disp.leds;
         sel_q  <= disp.digit_sel;
         fv_r   <= 1'b0;

         if (changed) begin
            cnt      <= '0;
            captured <= 1'b0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         if (capture) begin
            captured <= 1'b1;
            sh_bcd   <= nx_bcd;
            sh_dash  <= nx_dash;
            sh_err   <= nx_err;
            if (nx_seen == 4'b1111) begin
               bcd_r  <= nx_bcd;
               dash_r <= nx_dash;
               err_r  <= nx_err;
               fv_r   <= 1'b1;
               seen   <= 4'b0000;
            end else begin
               seen <= nx_seen;
            end
         end
      end
   end

   assign disp.bcd         = bcd_r;
   assign disp.dash        = dash_r;
   assign disp.err         = err_r;
   assign disp.frame_valid = fv_r;
endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - self-checking bench for seg7_capture
//
// Purpose: drives multiplexed display patterns into two instances
// (STABLE_CYCLES=4 and STABLE_CYCLES=1) and scores published frames.
// Ports: none.
module tb_seg7_capture;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seg7_capture_if d0 ();
   seg7_capture_if d1 ();

   seg7_capture #(.STABLE_CYCLES(4)) dut0 (.clk(clk), .rst(rst), .disp(d0));
   seg7_capture #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .disp(d1));

   // Expected frames: {bcd, dash, err}
   logic [23:0] q0[$];
   logic [23:0] q1[$];
   int          t1[$];
   int          fcount0 = 0;
   logic        fv0_prev = 1'b0;
   logic        fv1_prev = 1'b0;
   logic [23:0] e0;
   logic [23:0] e1;

   function automatic logic [0:6] seg(input int d);
      case (d)
         0:       seg = 7'b0000001;
         1:       seg = 7'b1001111;
         2:       seg = 7'b0010010;
         3:       seg = 7'b0000110;
         4:       seg = 7'b1001100;
         5:       seg = 7'b0100100;
         6:       seg = 7'b1100000;
         7:       seg = 7'b0001111;
         8:       seg = 7'b0000000;
         9:       seg = 7'b0001100;
         default: seg = 7'b1111111;
      endcase
   endfunction

   always @(negedge clk) begin
      if (d0.frame_valid === 1'b1) begin
         fcount0 = fcount0 + 1;
         checks = checks + 1;
         if (q0.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_frame0 got bcd=%h dash=%b err=%b, no frame expected",
                     d0.bcd, d0.dash, d0.err);
         end else begin
            e0 = q0.pop_front();
            if ({d0.bcd, d0.dash, d0.err} !== e0) begin
               errors = errors + 1;
               $display("FAIL frame0 got bcd=%h dash=%b err=%b expected bcd=%h dash=%b err=%b",
                        d0.bcd, d0.dash, d0.err, e0[23:8], e0[7:4], e0[3:0]);
            end
         end
         if (fv0_prev) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL fv0_consecutive frame_valid high two cycles in a row");
         end
      end
      fv0_prev = d0.frame_valid;
   end

   always @(negedge clk) begin
      if (d1.frame_valid === 1'b1) begin
         t1.push_back(cyc);
         checks = checks + 1;
         if (q1.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_frame1 got bcd=%h dash=%b err=%b, no frame expected",
                     d1.bcd, d1.dash, d1.err);
         end else begin
            e1 = q1.pop_front();
            if ({d1.bcd, d1.dash, d1.err} !== e1) begin
               errors = errors + 1;
               $display("FAIL frame1 got bcd=%h dash=%b err=%b expected bcd=%h dash=%b err=%b",
                        d1.bcd, d1.dash, d1.err, e1[23:8], e1[7:4], e1[3:0]);
            end
         end
         if (fv1_prev) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL fv1_consecutive frame_valid high two cycles in a row");
         end
      end
      fv1_prev = d1.frame_valid;
   end

   task automatic show0(input logic [3:0] sel, input logic [0:6] pat, input int n);
      d0.digit_sel = sel;
      d0.leds      = pat;
      repeat (n) @(negedge clk);
   endtask

   task automatic show1(input logic [3:0] sel, input logic [0:6] pat, input int n);
      d1.digit_sel = sel;
      d1.leds      = pat;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain0();
      for (int i = 0; i < 200 && q0.size() != 0; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      int fc;
      rst = 1'b1;
      repeat (2) begin
         d0.leds      = 7'($urandom);
         d0.digit_sel = 4'($urandom);
         @(negedge clk);
      end
      checks = checks + 4;
      if (d0.bcd !== 16'h0000) begin
         errors = errors + 1;
         $display("FAIL reset_bcd got %h expected 0000", d0.bcd);
      end
      if (d0.dash !== 4'b0000) begin
         errors = errors + 1;
         $display("FAIL reset_dash got %b expected 0000", d0.dash);
      end
      if (d0.err !== 4'b0000) begin
         errors = errors + 1;
         $display("FAIL reset_err got %b expected 0000", d0.err);
      end
      if (d0.frame_valid !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_frame_valid got %b expected 0", d0.frame_valid);
      end
      rst = 1'b0;
      // Two-cycle dwell on slot0 is too short to capture, so slots 1..3
      // alone must not complete a frame.
      fc = fcount0;
      show0(4'b1110, seg(1), 2);
      show0(4'b1101, seg(2), 6);
      show0(4'b1011, seg(3), 6);
      show0(4'b0111, seg(4), 6);
      show0(4'b1111, 7'b1111111, 10);
      checks = checks + 1;
      if (fcount0 !== fc) begin
         errors = errors + 1;
         $display("FAIL short_dwell_capture got %0d frames expected 0", fcount0 - fc);
      end
      q0.push_back({16'h4321, 4'b0000, 4'b0000});
      show0(4'b1110, seg(1), 6);
      show0(4'b1111, 7'b1111111, 4);
      wait_drain0();
      checks = checks + 1;
      if (q0.size() != 0) begin
         errors = errors + 1;
         $display("FAIL reset_followup_frame got %0d pending expected 0", q0.size());
      end
   endtask

   task automatic test_full_frame();
      q0.push_back({16'h4321, 4'b0000, 4'b0000});
      show0(4'b1110, 7'b1001111, 6);
      show0(4'b1101, 7'b0010010, 6);
      show0(4'b1011, 7'b0000110, 6);
      show0(4'b0111, 7'b1001100, 6);
      wait_drain0();
      checks = checks + 1;
      if (q0.size() != 0) begin
         errors = errors + 1;
         $display("FAIL full_frame got %0d pending expected 0", q0.size());
      end
   endtask

   task automatic test_special();
      q0.push_back({16'h8EEF, 4'b0001, 4'b0110});
      show0(4'b1110, 7'b1111110, 6);
      show0(4'b1101, 7'b1111111, 6);
      show0(4'b1011, 7'b0110000, 6);
      show0(4'b0111, 7'b0000000, 6);
      wait_drain0();
      checks = checks + 1;
      if (q0.size() != 0) begin
         errors = errors + 1;
         $display("FAIL special got %0d pending expected 0", q0.size());
      end
   endtask

   task automatic test_glitch_overlap();
      q0.push_back({16'h6950, 4'b0000, 4'b0000});
      show0(4'b1110, seg(0), 6);
      show0(4'b1101, seg(5), 6);
      show0(4'b1011, seg(8), 3);
      show0(4'b1011, seg(9), 6);
      show0(4'b0011, seg(8), 10);
      show0(4'b0111, seg(6), 6);
      wait_drain0();
      checks = checks + 1;
      if (q0.size() != 0) begin
         errors = errors + 1;
         $display("FAIL glitch_overlap got %0d pending expected 0", q0.size());
      end
   endtask

   task automatic test_overwrite();
      q0.push_back({16'h2227, 4'b0000, 4'b0000});
      show0(4'b1110, seg(5), 6);
      show0(4'b1110, seg(7), 6);
      show0(4'b1101, seg(2), 6);
      show0(4'b1011, seg(2), 6);
      show0(4'b0111, seg(2), 6);
      wait_drain0();
      checks = checks + 1;
      if (q0.size() != 0) begin
         errors = errors + 1;
         $display("FAIL overwrite got %0d pending expected 0", q0.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int fc;
      show0(4'b1110, seg(3), 6);
      show0(4'b1101, seg(3), 6);
      show0(4'b1011, seg(3), 6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks = checks + 1;
      if (d0.bcd !== 16'h0000) begin
         errors = errors + 1;
         $display("FAIL mid_reset_bcd got %h expected 0000", d0.bcd);
      end
      fc = fcount0;
      show0(4'b0111, seg(1), 6);
      show0(4'b1111, 7'b1111111, 6);
      checks = checks + 1;
      if (fcount0 !== fc) begin
         errors = errors + 1;
         $display("FAIL mid_reset_stale got %0d frames expected 0", fcount0 - fc);
      end
      q0.push_back({16'h1211, 4'b0000, 4'b0000});
      show0(4'b1110, seg(1), 6);
      show0(4'b1101, seg(1), 6);
      show0(4'b1011, seg(2), 6);
      wait_drain0();
      checks = checks + 1;
      if (q0.size() != 0) begin
         errors = errors + 1;
         $display("FAIL mid_reset_fresh got %0d pending expected 0", q0.size());
      end
   endtask

   task automatic test_back_to_back();
      t1.delete();
      q1.push_back({16'h4321, 4'b0000, 4'b0000});
      q1.push_back({16'h8765, 4'b0000, 4'b0000});
      q1.push_back({16'h2109, 4'b0000, 4'b0000});
      for (int f = 0; f < 3; f++) begin
         for (int s = 0; s < 4; s++) begin
            show1(~(4'b0001 << s), seg((f * 4 + s + 1) % 10), 2);
         end
      end
      show1(4'b1111, 7'b1111111, 4);
      checks = checks + 2;
      if (q1.size() != 0) begin
         errors = errors + 1;
         $display("FAIL b2b_drain got %0d pending expected 0", q1.size());
      end
      if (t1.size() != 3) begin
         errors = errors + 1;
         $display("FAIL b2b_count got %0d frames expected 3", t1.size());
      end else begin
         checks = checks + 2;
         if (t1[1] - t1[0] != 8) begin
            errors = errors + 1;
            $display("FAIL b2b_gap1 got %0d cycles expected 8", t1[1] - t1[0]);
         end
         if (t1[2] - t1[1] != 8) begin
            errors = errors + 1;
            $display("FAIL b2b_gap2 got %0d cycles expected 8", t1[2] - t1[1]);
         end
      end
   endtask

   initial begin
      d0.leds      = 7'b1111111;
      d0.digit_sel = 4'b1111;
      d1.leds      = 7'b1111111;
      d1.digit_sel = 4'b1111;
      @(negedge clk);
      test_reset();
      test_full_frame();
      test_special();
      test_glitch_overlap();
      test_overwrite();
      test_reset_mid_frame();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
